// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants, instruction field bounds and fetch FSM state
package proc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_BRANCH = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_ADD    = 4'h5;
  localparam logic [3:0] OP_ROT    = 4'h6;
  localparam logic [3:0] OP_SHIFT  = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'h8;
  localparam logic [3:0] OP_CMP    = 4'h9;

  localparam int OPC_HI        = 31;
  localparam int OPC_LO        = 28;
  localparam int CC_HI         = 27;
  localparam int CC_LO         = 24;
  localparam int SRC_TYPE_BIT  = 27;
  localparam int DEST_TYPE_BIT = 26;
  localparam int SRC_HI        = 23;
  localparam int SRC_LO        = 12;
  localparam int DEST_HI       = 11;
  localparam int DEST_LO       = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DROP,
    FETCH_HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - synchronous FIFO holding {pc, word} entries between fetch and decode
// Flush wins over push/pop; pop on empty and push on full are ignored.
module instr_queue #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM: one outstanding read, slot reservation, redirect and HALT stop
// Acked words land in instr_queue; decode pops them over valid/ready.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_t        state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic [ADDR_W-1:0]   addr_next;
  logic                req_next;
  logic                halted_next;
  logic                push;
  logic                flush;
  logic                outstanding;
  logic                has_space;
  logic [ENTRY_W-1:0]  head;

  // An issued request already owns a slot, so an ack can never find the queue full.
  assign outstanding = (state == FETCH_WAIT) || (state == FETCH_DROP);
  assign has_space   = (int'(fifo_count) + int'(outstanding)) < DEPTH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      halted   <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      mem_req  <= req_next;
      mem_addr <= addr_next;
      halted   <= halted_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_next    = mem_req;
    addr_next   = mem_addr;
    halted_next = halted;
    push        = 1'b0;
    flush       = 1'b0;
    if (redirect) begin
      flush       = 1'b1;
      pc_next     = redirect_pc;
      halted_next = 1'b0;
      case (state)
        // A still-pending read must complete before the next one may start.
        FETCH_WAIT, FETCH_DROP: begin
          if (mem_ack) begin
            req_next   = 1'b0;
            state_next = FETCH_IDLE;
          end else begin
            state_next = FETCH_DROP;
          end
        end
        default: state_next = FETCH_IDLE;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (!halted && has_space) begin
            req_next   = 1'b1;
            addr_next  = pc;
            state_next = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_ack) begin
            push     = 1'b1;
            pc_next  = pc + 1'b1;
            req_next = 1'b0;
            if (mem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
              halted_next = 1'b1;
              state_next  = FETCH_HALTED;
            end else begin
              state_next = FETCH_IDLE;
            end
          end
        end
        FETCH_DROP: begin
          if (mem_ack) begin
            req_next   = 1'b0;
            state_next = FETCH_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  instr_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pc, mem_rdata}),
    .pop       (instr_valid && instr_ready),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr_pc    = instr_valid ? head[ENTRY_W-1:DATA_W] : '0;
  assign instr_data  = instr_valid ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-programmable memory
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [11:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        halted;
  logic [2:0]  fifo_count;

  instr_fetch_unit #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (12'd2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  logic [43:0] exp_q [$];
  logic [11:0] exp_pc;
  bit          m_halted;
  bit          drop_pending;
  int          lat;
  bit          mem_hold;
  int          wait_cnt;
  int          n_acks;
  int          n_checks;
  int          n_errors;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: account for what the edge does, advance, check, then drive the memory side.
  task automatic step();
    logic [43:0] e;
    if (redirect) begin
      exp_q.delete();
      m_halted     = 1'b0;
      exp_pc       = redirect_pc;
      drop_pending = mem_req && !mem_ack;
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          expect_eq("pop_unexpected", 64'(instr_pc), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          expect_eq("pop_pc", 64'(instr_pc), 64'(e[43:32]));
          expect_eq("pop_data", 64'(instr_data), 64'(e[31:0]));
        end
      end
      if (mem_ack) begin
        if (drop_pending) begin
          drop_pending = 1'b0;
        end else begin
          expect_eq("fetch_addr", 64'(mem_addr), 64'(exp_pc));
          exp_q.push_back({mem_addr, mem_rdata});
          exp_pc = mem_addr + 12'd1;
          n_acks++;
          if (mem_rdata[31:28] == 4'h8) m_halted = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    expect_eq("count", 64'(fifo_count), 64'(exp_q.size()));
    expect_eq("valid", 64'(instr_valid), 64'(exp_q.size() != 0));
    expect_eq("halted", 64'(halted), 64'(m_halted));
    expect_eq("space", 64'((int'(fifo_count) + int'(mem_req)) <= 4), 64'd1);
    if (!instr_valid) expect_eq("empty_head", {20'd0, instr_pc, instr_data}, 64'd0);
    if (m_halted) expect_eq("halt_noreq", 64'(mem_req), 64'd0);
    if (mem_req) begin
      wait_cnt++;
      if (wait_cnt >= lat && !mem_hold) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      wait_cnt = 0;
      mem_ack  = 1'b0;
    end
  endtask

  task automatic do_redirect(input logic [11:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[2] = 32'h5000_0001;
    mem[5] = 32'h8000_0000;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    exp_pc = 12'd2; m_halted = 0; drop_pending = 0; lat = 1; mem_hold = 0;
    wait_cnt = 0; n_acks = 0; n_checks = 0; n_errors = 0;

    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_outs", {mem_req, mem_addr, instr_valid, instr_data, instr_pc, halted, fifo_count},
              64'd0);
    reset = 1'b0;

    // Basic stream from RESET_PC, running into the HALT at address 5
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    expect_eq("first_valid", 64'(instr_valid), 64'd1);
    expect_eq("first_pc", 64'(instr_pc), 64'd2);
    expect_eq("first_data", 64'(instr_data), 64'h5000_0001);
    for (int i = 0; i < 40 && !halted; i++) step();
    expect_eq("halt_set", 64'(halted), 64'd1);
    expect_eq("halt_req", 64'(mem_req), 64'd0);
    repeat (8) step();
    expect_eq("halt_drained", 64'(instr_valid), 64'd0);

    // Redirect out of HALTED
    do_redirect(12'd0);
    expect_eq("halt_clear", 64'(halted), 64'd0);
    for (int i = 0; i < 5 && !mem_req; i++) step();
    expect_eq("resume_addr", {31'd0, mem_req, 20'd0, mem_addr}, {31'd0, 1'b1, 32'd0});
    for (int i = 0; i < 60 && !halted; i++) step();
    expect_eq("halt_again", 64'(halted), 64'd1);

    // Backpressure: exactly DEPTH acks, then no requests
    instr_ready = 1'b0;
    do_redirect(12'h100);
    n_acks = 0;
    repeat (30) step();
    expect_eq("bp_acks", 64'(n_acks), 64'd4);
    expect_eq("bp_count", 64'(fifo_count), 64'd4);
    expect_eq("bp_noreq", 64'(mem_req), 64'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    expect_eq("bp_resume", 64'(mem_req), 64'd1);
    repeat (10) step();

    // Redirect while the read of address 7 is still pending
    lat = 5;
    do_redirect(12'd7);
    for (int i = 0; i < 30 && !(mem_req && mem_addr == 12'd7); i++) step();
    expect_eq("pend7_seen", {mem_req, mem_addr}, {1'b1, 12'd7});
    do_redirect(12'd20);
    expect_eq("drop_count", 64'(fifo_count), 64'd0);
    expect_eq("drop_hold", {mem_req, mem_addr}, {1'b1, 12'd7});
    for (int i = 0; i < 20 && !(mem_req && mem_addr != 12'd7); i++) step();
    expect_eq("after_drop_addr", {mem_req, mem_addr}, {1'b1, 12'd20});
    repeat (6) step();

    // Redirect coincident with an ack and a pop
    lat = 3;
    instr_ready = 1'b0;
    for (int i = 0; i < 40 && !(fifo_count != 0 && mem_ack); i++) step();
    expect_eq("coinc_setup", 64'(fifo_count != 0 && mem_ack), 64'd1);
    instr_ready = 1'b1;
    do_redirect(12'h080);
    expect_eq("coinc_count", 64'(fifo_count), 64'd0);
    expect_eq("coinc_valid", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 10 && !mem_req; i++) step();
    expect_eq("coinc_addr", {mem_req, mem_addr}, {1'b1, 12'h080});
    repeat (6) step();

    // PC wrap
    lat = 1;
    do_redirect(12'hFFF);
    for (int i = 0; i < 10 && !(mem_req && mem_addr == 12'hFFF); i++) step();
    expect_eq("wrap_fff", {mem_req, mem_addr}, {1'b1, 12'hFFF});
    for (int i = 0; i < 10 && !(mem_req && mem_addr != 12'hFFF); i++) step();
    expect_eq("wrap_000", {mem_req, mem_addr}, {1'b1, 12'h000});
    repeat (4) step();

    // Reset asserted mid-request
    mem_hold = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    expect_eq("rst_pending", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    expect_eq("rst_async", {mem_req, mem_addr, instr_valid, instr_data, instr_pc, halted, fifo_count},
              64'd0);
    exp_q.delete();
    exp_pc = 12'd2; m_halted = 0; drop_pending = 0; wait_cnt = 0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    expect_eq("rst_restart", {mem_req, mem_addr}, {1'b1, 12'd2});
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch front end for the multi-cycle processor: reads 32-bit instruction words from word-addressed memory and buffers them in a small queue.
- Hands each word and its PC to the decode stage over a valid/ready handshake.
- Handles branch redirect with a queue flush and in-flight discard.
- Stops fetching after a HALT opcode has been enqueued.

Parameters:
- ADDR_W, 12, width of PC and memory word address (matches 12-bit instruction address fields).
- DATA_W, 32, instruction word width.
- DEPTH, 4, queue entries (power of 2, >=2).
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request; held high until mem_ack.
- mem_addr  out  ADDR_W  word address; stable while mem_req=1.
- mem_ack  in  1  read data valid this cycle; completes the request.
- mem_rdata  in  DATA_W  instruction word, sampled when mem_ack=1.
- instr_valid  out  1  queue head valid.
- instr_data  out  DATA_W  queue head word.
- instr_pc  out  ADDR_W  address of the queue head word.
- instr_ready  in  1  decode accepts the head (pop when valid & ready).
- redirect  in  1  branch taken or restart; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address.
- halted  out  1  fetch stopped after a HALT.
- fifo_count  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async, active-high) state: pc=RESET_PC; queue empty; FSM in IDLE. All outputs 0: mem_req, mem_addr, instr_valid, instr_data, instr_pc, halted, fifo_count.
- Empty queue: instr_data and instr_pc are forced to 0 whenever instr_valid=0.
- At most one memory request is outstanding at any time.
- A request may be issued only if fifo_count + outstanding < DEPTH. This guarantees an acked word always has a slot.
- FSM states:
  - IDLE: if not halted and there is space, register mem_req=1 and mem_addr=pc at the next edge, then go to WAIT.
  - WAIT: hold mem_req and mem_addr.
    - On mem_ack: push {pc, mem_rdata}; pc <= pc+1, wrapping modulo 2^ADDR_W; drop mem_req.
    - If mem_rdata[31:28]==4'b1000 (HALT), set halted=1 and go to HALTED. Otherwise go to IDLE.
    - Back-to-back requests are allowed: if space remains, mem_req re-asserts the edge after the ack cycle.
  - DROP: hold mem_req and the old mem_addr until mem_ack, discard the data, then go to IDLE.
  - HALTED: no requests; the queue still drains to decode. Leave only on redirect.
- Timing: req is issued at edge N, ack is seen at edge N+k (k>=1), and instr_valid is high after edge N+k (push is visible the cycle after ack).
- Pop: when instr_valid & instr_ready, the head is removed at the edge. Simultaneous push and pop leaves the count unchanged.
- Redirect has highest priority and takes effect at the sampling edge:
  - Queue flushed to empty (a pop in the same cycle is ignored); pc <= redirect_pc; halted <= 0.
  - If WAIT and no mem_ack that cycle: go to DROP.
  - If mem_ack in the same cycle: data discarded, go to IDLE.
  - Otherwise: go to IDLE.
- Redirect while in DROP: pc is updated and the state stays DROP.
- Opcode 0000 (NOP) and all other opcodes pass through unmodified. Only HALT is predecoded.
- Reset asserted mid-request: all state is cleared immediately. The memory side must tolerate mem_req dropping without an ack.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants: OP_NOP=4'h0, OP_LOAD=1, OP_STORE=2, OP_BRANCH=3, OP_XOR=4, OP_ADD=5, OP_ROT=6, OP_SHIFT=7, OP_HALT=8, OP_CMP=9.
  - field bounds: opcode 31:28, cc 27:24, src_type 27, dest_type 26, src 23:12, dest 11:0.
  - fetch FSM state enum.
- One sub-module, instr_queue: a synchronous FIFO of {ADDR_W+DATA_W} bits with push, pop, flush and count. The fetch unit holds the FSM, pc and space reservation.

Test Plan:
- Basic stream: reset, RESET_PC=2, memory acks with 1-cycle latency returning 32'h5000_0001 at addr 2 and NOPs after, instr_ready=1 -> mem_addr sequence 2,3,4..., first instr_valid with instr_pc=2, data 32'h50000001.
- Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 acks, fifo_count=4, mem_req stays 0. Release ready -> words emerge in order with pcs n..n+3 and requests resume.
- HALT: word 32'h8000_0000 at addr 5 -> after its ack, halted=1 and no mem_req. The queue drains including the HALT word. Redirect to 0 -> halted=0, fetch resumes at 0.
- Redirect in flight: mem_req with addr 7 pending, redirect_pc=20 with ack 3 cycles later -> addr-7 data never appears, fifo_count=0 after redirect, next mem_addr=20.
- Redirect coincident with mem_ack and pop -> queue empty, acked word discarded, next mem_addr=redirect_pc.
- Wrap and reset: pc=12'hFFF -> next mem_addr 12'h000. Assert reset mid-WAIT -> all outputs 0 asynchronously, restart at RESET_PC.
